// File: rtl/cabac_debina_se_if.sv
// Handshake bundle between the SE parser / arithmetic decoder and the CABAC de-binarizer.
// The slave modport is the de-binarizer side.
interface cabac_debina_se_if #(parameter int VAL_W = 16) ();
  logic             start_i;
  logic             start_rdy_o;
  logic [2:0]       bina_type_i;
  logic [3:0]       cmax_i;
  logic [2:0]       rice_i;
  logic             bin_vld_i;
  logic             bin_i;
  logic             bin_rdy_o;
  logic             done_o;
  logic [VAL_W-1:0] val_o;
  logic             err_o;

  modport slave (
    input  start_i, bina_type_i, cmax_i, rice_i, bin_vld_i, bin_i,
    output start_rdy_o, bin_rdy_o, done_o, val_o, err_o
  );

  modport master (
    output start_i, bina_type_i, cmax_i, rice_i, bin_vld_i, bin_i,
    input  start_rdy_o, bin_rdy_o, done_o, val_o, err_o
  );
endinterface

// File: rtl/cabac_debina_se.sv
// CABAC de-binarizer: rebuilds an FL / TU / EG1 / CREG syntax-element value from
// decoded bins, one bin per cycle, with a registered done/err/val result.
module cabac_debina_se #(
  parameter int VAL_W   = 16,
  parameter int PFX_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  cabac_debina_se_if.slave bus
);
  localparam int CNT_W = $clog2(PFX_MAX + 1);
  localparam logic [2:0] T_FL = 3'd0, T_TU = 3'd1, T_EG1 = 3'd2, T_CREG = 3'd4;
  localparam logic [VAL_W-1:0] ONE = VAL_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_SUFFIX} state_e;

  state_e           state_q, state_d;
  logic [2:0]       type_q, type_d;
  logic [3:0]       cmax_q, cmax_d;
  logic [2:0]       rice_q, rice_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [VAL_W-1:0] sfx_q, sfx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [VAL_W-1:0] val_q, val_d;

  logic [CNT_W-1:0] cnt_inc, fl_len, creg_len;
  logic [VAL_W-1:0] creg_base;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // FL length is the MSB position of cMax plus one
  always_comb begin
    fl_len = '0;
    for (int i = 0; i < 4; i++)
      if (cmax_q[i]) fl_len = CNT_W'(i + 1);
  end

  // CREG suffix length and base value from the completed prefix count
  always_comb begin
    if (cnt_q < CNT_W'(3)) begin
      creg_len  = CNT_W'(rice_q);
      creg_base = VAL_W'(cnt_q) << rice_q;
    end else begin
      creg_len  = cnt_q - CNT_W'(3) + CNT_W'(rice_q);
      creg_base = ((ONE << (cnt_q - CNT_W'(3))) + VAL_W'(2)) << rice_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      cmax_q  <= '0;
      rice_q  <= '0;
      acc_q   <= '0;
      sfx_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cmax_q  <= cmax_d;
      rice_q  <= rice_d;
      acc_q   <= acc_d;
      sfx_q   <= sfx_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cmax_d  = cmax_q;
    rice_d  = rice_q;
    acc_d   = acc_q;
    sfx_d   = sfx_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    val_d   = val_q;
    case (state_q)
      S_IDLE: if (bus.start_i) begin
        type_d = bus.bina_type_i;
        cmax_d = bus.cmax_i;
        rice_d = bus.rice_i;
        acc_d  = '0;
        sfx_d  = '0;
        cnt_d  = '0;
        rem_d  = '0;
        case (bus.bina_type_i)
          T_FL, T_TU: begin
            if (bus.cmax_i == 4'd0) begin
              done_d = 1'b1;
              val_d  = '0;
            end else begin
              state_d = S_PREFIX;
            end
          end
          T_EG1, T_CREG: state_d = S_PREFIX;
          default: begin
            done_d = 1'b1;
            err_d  = 1'b1;
            val_d  = '0;
          end
        endcase
      end
      S_PREFIX: if (bus.bin_vld_i) begin
        case (type_q)
          T_FL: begin
            acc_d = (acc_q << 1) | VAL_W'(bus.bin_i);
            cnt_d = cnt_inc;
            if (cnt_inc == fl_len) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              val_d   = acc_d;
            end
          end
          T_TU: begin
            if (bus.bin_i) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_W'(cmax_q)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                val_d   = VAL_W'(cnt_inc);
              end
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              val_d   = VAL_W'(cnt_q);
            end
          end
          T_EG1, T_CREG: begin
            if (bus.bin_i) begin
              cnt_d = cnt_inc;
              // EG1: k = cnt+1 before the increment, so the weight is 1<<cnt_inc
              if (type_q == T_EG1) acc_d = acc_q + (ONE << cnt_inc);
              if (cnt_inc == CNT_W'(PFX_MAX)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                val_d   = '0;
              end
            end else if (type_q == T_EG1) begin
              state_d = S_SUFFIX;
              rem_d   = cnt_inc;
            end else if (creg_len == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              val_d   = creg_base;
            end else begin
              state_d = S_SUFFIX;
              acc_d   = creg_base;
              rem_d   = creg_len;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_SUFFIX: if (bus.bin_vld_i) begin
        sfx_d = (sfx_q << 1) | VAL_W'(bus.bin_i);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          val_d   = acc_q + sfx_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.start_rdy_o = (state_q == S_IDLE);
  assign bus.bin_rdy_o   = (state_q != S_IDLE);
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.val_o       = val_q;
endmodule

// File: tb/tb_cabac_debina_se.sv
// Bench for cabac_debina_se: directed vector table, hand-written reset/back-to-back
// sequences, and random SEs checked against a value-level reference model.
module tb_cabac_debina_se;
  localparam int VAL_W = 16;
  localparam int PFX   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  cabac_debina_se_if #(.VAL_W(VAL_W)) bus ();

  cabac_debina_se #(.VAL_W(VAL_W), .PFX_MAX(PFX)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          typ;
    int          cmax;
    int          rice;
    logic [63:0] b;
    int          nb;
    int          gm;
    int          ev;
    bit          ee;
    int          eu;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: decode a bin stream (b[i] is the i-th bin) straight from the binarization rules
  function automatic void model(input int typ, input int cmax, input int rice, input logic [63:0] b,
                                output int val, output bit err, output int used);
    int p, n, len;
    longint v, s;
    val = 0; err = 1'b0; used = 0;
    case (typ)
      0: begin
        n = 0;
        while ((cmax >> n) != 0) n++;
        v = 0;
        for (int i = 0; i < n; i++) v = v * 2 + longint'(b[i]);
        used = n;
        val  = int'(v);
      end
      1: begin
        p = 0;
        while (p < cmax && b[p]) p++;
        used = (p == cmax) ? p : p + 1;
        val  = p;
      end
      2, 4: begin
        p = 0;
        while (p < PFX && b[p]) p++;
        if (p == PFX) begin
          err  = 1'b1;
          used = PFX;
        end else begin
          if (typ == 2) begin
            len = p + 1;
            v   = (longint'(1) << (p + 1)) - 2;
          end else if (p < 3) begin
            len = rice;
            v   = longint'(p) << rice;
          end else begin
            len = p - 3 + rice;
            v   = ((longint'(1) << (p - 3)) + 2) << rice;
          end
          s = 0;
          for (int i = 0; i < len; i++) s = s * 2 + longint'(b[p + 1 + i]);
          used = p + 1 + len;
          val  = int'((v + s) & 64'hFFFF);
        end
      end
      default: err = 1'b1;
    endcase
  endfunction

  // Starts an SE at the current negedge and feeds bins until done_o or a cycle budget runs out.
  // gm: 0 no gaps, 1 random gaps, 2 one idle cycle after the first bin.
  task automatic run_se(input int typ, input int cmax, input int rice, input logic [63:0] b,
                        input int nb, input int gm, input string nm,
                        output int val, output bit err, output int used, output bit to);
    bit gapped;
    int cyc;
    gapped = 1'b0; cyc = 0;
    val = 0; err = 1'b0; used = 0; to = 1'b0;
    bus.start_i     = 1'b1;
    bus.bina_type_i = 3'(typ);
    bus.cmax_i      = 4'(cmax);
    bus.rice_i      = 3'(rice);
    bus.bin_vld_i   = 1'b0;
    forever begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.done_o) begin
        val = int'(bus.val_o);
        err = bus.err_o;
        break;
      end
      chk({nm, ".err_without_done"}, int'(bus.err_o), 0);
      cyc++;
      if (cyc > 300) begin
        to = 1'b1;
        break;
      end
      bus.bin_vld_i = 1'b0;
      if (used < nb) begin
        if (gm == 1 && $urandom_range(2) == 0) bus.bin_vld_i = 1'b0;
        else if (gm == 2 && used == 1 && !gapped) gapped = 1'b1;
        else bus.bin_vld_i = 1'b1;
        bus.bin_i = b[used];
      end
      if (bus.bin_vld_i && bus.bin_rdy_o) used++;
    end
    bus.bin_vld_i = 1'b0;
  endtask

  task automatic check_se(input string nm, input int gv, input bit ge, input int gu, input bit to,
                          input int ev, input bit ee, input int eu);
    chk({nm, ".timeout"}, int'(to), 0);
    chk({nm, ".val"}, gv, ev);
    chk({nm, ".err"}, int'(ge), int'(ee));
    chk({nm, ".bins_used"}, gu, eu);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[13];
    int   gv, gu;
    bit   ge, to;

    tv[0]  = '{"fl_c7_gap",   0, 7,  0, 64'b101,     3, 2, 5,  1'b0, 3};
    tv[1]  = '{"tu_c2",       1, 2,  0, 64'b011,     3, 0, 2,  1'b0, 2};
    tv[2]  = '{"tu_c4",       1, 4,  0, 64'b01,      2, 0, 1,  1'b0, 2};
    tv[3]  = '{"tu_c0",       1, 0,  0, 64'b111,     3, 0, 0,  1'b0, 0};
    tv[4]  = '{"eg1_5",       2, 0,  0, 64'b1101,    4, 0, 5,  1'b0, 4};
    tv[5]  = '{"creg_r1",     4, 0,  1, 64'b1011,    4, 0, 5,  1'b0, 4};
    tv[6]  = '{"creg_r0_p4",  4, 0,  0, 64'b101111,  6, 0, 5,  1'b0, 6};
    tv[7]  = '{"creg_r0_0",   4, 0,  0, 64'b0,       1, 0, 0,  1'b0, 1};
    tv[8]  = '{"sp_err",      5, 3,  2, 64'b111,     3, 0, 0,  1'b1, 0};
    tv[9]  = '{"creg_ovf",    4, 0,  2, 64'h1FFFF,  17, 0, 0,  1'b1, 16};
    tv[10] = '{"fl_c15",      0, 15, 0, 64'b1101,    4, 1, 11, 1'b0, 4};
    tv[11] = '{"eg1_ovf",     2, 0,  0, 64'h1FFFF,  17, 1, 0,  1'b1, 16};
    tv[12] = '{"undef3_err",  3, 1,  0, 64'b1,       1, 0, 0,  1'b1, 0};

    bus.start_i = 1'b0; bus.bina_type_i = '0; bus.cmax_i = '0; bus.rice_i = '0;
    bus.bin_vld_i = 1'b0; bus.bin_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.start_rdy", int'(bus.start_rdy_o), 1);
    chk("rst.bin_rdy",   int'(bus.bin_rdy_o), 0);
    chk("rst.done",      int'(bus.done_o), 0);
    chk("rst.err",       int'(bus.err_o), 0);
    chk("rst.val",       int'(bus.val_o), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_se(tv[i].typ, tv[i].cmax, tv[i].rice, tv[i].b, tv[i].nb, tv[i].gm, tv[i].nm, gv, ge, gu, to);
      check_se(tv[i].nm, gv, ge, gu, to, tv[i].ev, tv[i].ee, tv[i].eu);
      chk({tv[i].nm, ".start_rdy_at_done"}, int'(bus.start_rdy_o), 1);
      @(negedge clk);
      chk({tv[i].nm, ".done_one_cycle"}, int'(bus.done_o), 0);
    end

    // Back-to-back: second start issued in the done cycle of the first
    run_se(2, 0, 0, 64'b1101, 4, 0, "b2b_a", gv, ge, gu, to);
    check_se("b2b_a", gv, ge, gu, to, 5, 1'b0, 4);
    run_se(2, 0, 0, 64'b10, 2, 0, "b2b_b", gv, ge, gu, to);
    check_se("b2b_b", gv, ge, gu, to, 1, 1'b0, 2);

    // Random SEs against the reference model
    for (int t = 0; t < 120; t++) begin
      int          typ, cmax, rice, ln, ev, eu;
      bit          ee;
      logic [63:0] b;
      case ($urandom_range(9))
        0, 4: typ = 0;
        1, 5: typ = 1;
        2, 6: typ = 2;
        3, 7: typ = 4;
        8:    typ = 5;
        default: typ = ($urandom_range(1) == 1) ? 3 : 7;
      endcase
      cmax = $urandom_range(15);
      rice = $urandom_range(4);
      b    = {$urandom(), $urandom()};
      ln   = $urandom_range(17);
      b    = b | ((64'd1 << ln) - 64'd1);
      model(typ, cmax, rice, b, ev, ee, eu);
      run_se(typ, cmax, rice, b, 64, 1, $sformatf("rnd%0d_t%0d", t, typ), gv, ge, gu, to);
      check_se($sformatf("rnd%0d_t%0d", t, typ), gv, ge, gu, to, ev, ee, eu);
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    // Reset in the middle of an EG1 suffix
    run_se(0, 15, 0, 64'hF, 4, 0, "pre_rst", gv, ge, gu, to);
    check_se("pre_rst", gv, ge, gu, to, 15, 1'b0, 4);
    bus.start_i = 1'b1; bus.bina_type_i = 3'd2; bus.cmax_i = '0; bus.rice_i = '0;
    @(negedge clk);
    bus.start_i = 1'b0; bus.bin_vld_i = 1'b1; bus.bin_i = 1'b1;
    @(negedge clk);
    bus.bin_i = 1'b0;
    @(negedge clk);
    bus.bin_i = 1'b1;
    @(negedge clk);
    bus.bin_vld_i = 1'b0;
    chk("mid.in_suffix_bin_rdy", int'(bus.bin_rdy_o), 1);
    chk("mid.no_early_done", int'(bus.done_o), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.start_rdy", int'(bus.start_rdy_o), 1);
    chk("arst.bin_rdy",   int'(bus.bin_rdy_o), 0);
    chk("arst.done",      int'(bus.done_o), 0);
    chk("arst.err",       int'(bus.err_o), 0);
    chk("arst.val",       int'(bus.val_o), 0);
    repeat (2) begin
      @(negedge clk);
      chk("arst.hold_done", int'(bus.done_o), 0);
    end
    rst = 1'b0;
    bus.bin_vld_i = 1'b1; bus.bin_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst.no_done",  int'(bus.done_o), 0);
      chk("post_rst.idle_rdy", int'(bus.bin_rdy_o), 0);
    end
    bus.bin_vld_i = 1'b0;
    run_se(0, 1, 0, 64'b1, 1, 0, "post_rst_fl1", gv, ge, gu, to);
    check_se("post_rst_fl1", gv, ge, gu, to, 1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cabac_debina_se.md
Name: cabac_debina_se

Overview:
- Decoder-side CABAC de-binarizer: consumes decoded bins one per cycle from the arithmetic decoding engine and rebuilds the syntax-element value.
- Covers FL, TU, EG1 and CREG (coeff_abs_level_remaining) binarizations.
- Inverse of the encoder binarization LUT/binarizer: uses the same binaType codes and cMax semantics, and is driven per SE by the parser with type, cMax and cRiceParam.

Parameters:
- VAL_W, 16: width of the reconstructed value; arithmetic wraps modulo 2^VAL_W.
- PFX_MAX, 16: CREG/EG1 prefix cap (count of consecutive 1 bins) at which decoding aborts with an error.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  SE request; accepted when start_i & start_rdy_o.
- start_rdy_o  output  1  high in IDLE.
- bina_type_i  input  3  FL=0, TU=1, EG1=2, CREG=4, SP=5; sampled on start.
- cmax_i  input  4  cMax for FL/TU; sampled on start.
- rice_i  input  3  cRiceParam (0..4) for CREG; sampled on start.
- bin_vld_i  input  1  bin available.
- bin_i  input  1  bin value.
- bin_rdy_o  output  1  high in PREFIX/SUFFIX; a bin is consumed when bin_vld_i & bin_rdy_o.
- done_o  output  1  one-cycle pulse, value ready.
- val_o  output  VAL_W  decoded value; held until the next done_o.
- err_o  output  1  qualifies done_o: unsupported type or prefix overflow.

Behaviour:
- Reset: state=IDLE; start_rdy_o=1; bin_rdy_o=0; done_o=0; err_o=0; val_o=0; all internal counters=0.
- Reset is asynchronous and effective mid-decode; partial bins are discarded. No done_o is produced for the aborted SE.
- States: IDLE, PREFIX, SUFFIX. One bin is consumed per cycle at most. Idle cycles on bin_vld_i stall the FSM with no state change.
- Start in IDLE: latch type, cMax, rice. Clear acc, cnt and k. Go to PREFIX, except in the immediate cases below.
- Immediate cases:
  - FL/TU with cMax=0: no bins consumed; done_o next cycle with val=0.
  - SP or any undefined type: no bins consumed; done_o and err_o next cycle with val=0.
- FL:
  - Length n = index of MSB of cMax + 1 (cMax=1→1, 3→2, 7→3, 15→4).
  - Bins are read MSB first.
  - After n bins: val = collected bits. No clipping against cMax.
- TU:
  - Each 1 bin increments cnt.
  - Stop on a 0 bin, or when cnt reaches cMax. In the cMax case no terminating 0 is read.
  - val = cnt.
- EG1:
  - Start with k=1.
  - PREFIX: each 1 bin does acc += 1<<k, then k++.
  - A 0 bin moves to SUFFIX and reads k bits MSB first. val = acc + suffix.
- CREG:
  - PREFIX: count 1 bins (p) until a 0 bin.
  - If p<3: suffix length = rice; val = (p<<rice) + suffix.
  - Else: suffix length = p-3+rice; val = (((1<<(p-3))+2)<<rice) + suffix.
  - A zero-length suffix completes at the terminating 0 bin.
- Prefix overflow: if p (CREG) or the number of 1 bins (EG1) reaches PFX_MAX, stop consuming bins. done_o and err_o fire next cycle with val=0.
- Timing:
  - done_o is registered and asserts the cycle after the final bin is accepted. The FSM is already in IDLE in that cycle, so start_rdy_o=1.
  - A new start may be accepted in the same cycle as done_o (back-to-back SEs).
  - Minimum latency: 1 bin → done at cycle+1.
- bin_rdy_o is never high in IDLE. Bins presented then are not consumed.
- err_o is low whenever done_o is low.

Test Plan:
- FL, cMax=7, bins 1,0,1 (with one bin_vld_i gap after bin 1) → exactly 3 bins consumed; done_o after the last with val=5, err=0.
- TU: cMax=2, bins 1,1 → val=2 after 2 bins, no terminator read. Then cMax=4, bins 1,0 → val=1. Then cMax=0 → done next cycle, val=0, bin_rdy_o never high.
- EG1: bins 1,0,1,1 → val=5 (acc=2, k=2, suffix=3). Back-to-back start in the done cycle, bins 0,1 → val=1.
- CREG: rice=1, bins 1,1,0,1 → val=5. rice=0, bins 1,1,1,1,0,1 → val=5. rice=0, bin 0 → val=0 after 1 bin.
- Errors: bina_type=5 → done+err next cycle, val=0, no bins consumed. CREG with 16 consecutive 1 bins → done+err, 17th bin not consumed.
- Reset asserted mid-EG1 suffix → outputs return to reset values immediately (asynchronously). No done_o occurs. Next SE (FL cMax=1, bin 1) → val=1.
